// File: rtl/ts_output_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ts_output_arbiter_pkg
// Shared constants and types for the TS output arbiter:
//   - TS packet geometry and sync byte
//   - null packet header bytes (PID 0x1FFF, payload only, CC 0)
//   - 2-bit source-select encoding
//   - null_byte(): byte n of a null packet
// ---------------------------------------------------------------------------
package ts_output_arbiter_pkg;

    localparam int          TS_PKT_LEN = 188;
    localparam logic [7:0]  LAST_BYTE  = 8'(TS_PKT_LEN - 1);
    localparam logic [7:0]  TS_SYNC    = 8'h47;
    localparam logic [12:0] NULL_PID   = 13'h1FFF;

    // Null header: 47 | 000,PID[12:8] | PID[7:0] | 0001_0000 (payload only, CC 0)
    localparam logic [7:0]  NULL_HDR1  = {3'b000, NULL_PID[12:8]};
    localparam logic [7:0]  NULL_HDR2  = NULL_PID[7:0];
    localparam logic [7:0]  NULL_HDR3  = 8'h10;
    localparam logic [7:0]  NULL_FILL  = 8'hFF;

    typedef enum logic [1:0] {
        SEL_PAT  = 2'd0,
        SEL_PMT  = 2'd1,
        SEL_T2MI = 2'd2,
        SEL_NULL = 2'd3
    } sel_e;

    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        case (idx)
            8'd0:    return TS_SYNC;
            8'd1:    return NULL_HDR1;
            8'd2:    return NULL_HDR2;
            8'd3:    return NULL_HDR3;
            default: return NULL_FILL;
        endcase
    endfunction

endpackage

// File: rtl/ts_output_arbiter_if.sv
// ---------------------------------------------------------------------------
// ts_output_arbiter_if
// Bundles the source-side and pin-side signals of the TS output arbiter.
//   OUT_ENA              byte slot enable
//   T2MI_REQ/DATA/RD     T2-MI packetiser (show-ahead, RD consumes)
//   PAT_DATA/RD          PAT generator (always ready)
//   PMT_DATA/RD          PMT generator (always ready)
//   DATA_OUT/DVALID_OUT/PSYNC_OUT  registered TS output
// modport master: the arbiter; modport slave: sources and output sink.
// ---------------------------------------------------------------------------
interface ts_output_arbiter_if;

    logic       OUT_ENA;
    logic       T2MI_REQ;
    logic [7:0] T2MI_DATA;
    logic       T2MI_RD;
    logic [7:0] PAT_DATA;
    logic       PAT_RD;
    logic [7:0] PMT_DATA;
    logic       PMT_RD;
    logic [7:0] DATA_OUT;
    logic       DVALID_OUT;
    logic       PSYNC_OUT;

    modport master (
        input  OUT_ENA, T2MI_REQ, T2MI_DATA, PAT_DATA, PMT_DATA,
        output T2MI_RD, PAT_RD, PMT_RD, DATA_OUT, DVALID_OUT, PSYNC_OUT
    );

    modport slave (
        output OUT_ENA, T2MI_REQ, T2MI_DATA, PAT_DATA, PMT_DATA,
        input  T2MI_RD, PAT_RD, PMT_RD, DATA_OUT, DVALID_OUT, PSYNC_OUT
    );

endinterface

// File: rtl/ts_output_arbiter.sv
// ---------------------------------------------------------------------------
// ts_output_arbiter
// Packet-level arbiter for the final TS byte stream. Each 188-byte slot is
// granted at byte 0 to PAT, PMT, T2-MI or a generated null packet (fixed
// priority in that order), and the grant holds for the whole packet.
// PAT/PMT are forced due every PSI_PERIOD output packets; their CC nibble
// in header byte 3 is owned and rewritten here.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   bus        ts_output_arbiter_if.master (sources, RD strobes, TS output)
// ---------------------------------------------------------------------------
module ts_output_arbiter
    import ts_output_arbiter_pkg::*;
#(
    parameter int PSI_PERIOD = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    ts_output_arbiter_if.master   bus
);

    localparam logic [15:0] PCNT_LAST = 16'(PSI_PERIOD - 1);

    logic [7:0]  r_bcnt;
    sel_e        r_sel;
    logic [15:0] r_pcnt;
    logic        r_pat_due;
    logic        r_pmt_due;
    logic [3:0]  r_cc_pat;
    logic [3:0]  r_cc_pmt;
    logic [7:0]  r_data;
    logic        r_dvalid;
    logic        r_psync;

    logic        w_boundary;
    logic        w_last;
    logic        w_fire;
    sel_e        w_pick;
    sel_e        w_sel;
    logic [7:0]  w_byte;

    assign w_boundary = (r_bcnt == 8'd0);
    assign w_last     = (r_bcnt == LAST_BYTE);
    // No byte is consumed while reset is held, so sources and arbiter stay aligned.
    assign w_fire     = bus.OUT_ENA && !RST;

    always_comb begin
        if (r_pat_due)         w_pick = SEL_PAT;
        else if (r_pmt_due)    w_pick = SEL_PMT;
        else if (bus.T2MI_REQ) w_pick = SEL_T2MI;
        else                   w_pick = SEL_NULL;
    end

    // Byte 0 uses the fresh decision; bytes 1..187 use the latched grant.
    assign w_sel = w_boundary ? w_pick : r_sel;

    assign bus.PAT_RD  = w_fire && (w_sel == SEL_PAT);
    assign bus.PMT_RD  = w_fire && (w_sel == SEL_PMT);
    assign bus.T2MI_RD = w_fire && (w_sel == SEL_T2MI);

    // PSI header byte 3 carries the locally owned continuity counter.
    always_comb begin
        w_byte = null_byte(r_bcnt);
        case (w_sel)
            SEL_PAT:  w_byte = (r_bcnt == 8'd3) ? {bus.PAT_DATA[7:4], r_cc_pat} : bus.PAT_DATA;
            SEL_PMT:  w_byte = (r_bcnt == 8'd3) ? {bus.PMT_DATA[7:4], r_cc_pmt} : bus.PMT_DATA;
            SEL_T2MI: w_byte = bus.T2MI_DATA;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bcnt    <= 8'd0;
            r_sel     <= SEL_NULL;
            r_pcnt    <= 16'd0;
            r_pat_due <= 1'b1;
            r_pmt_due <= 1'b1;
            r_cc_pat  <= 4'd0;
            r_cc_pmt  <= 4'd0;
            r_data    <= 8'd0;
            r_dvalid  <= 1'b0;
            r_psync   <= 1'b0;
        end else if (bus.OUT_ENA) begin
            r_data   <= w_byte;
            r_dvalid <= 1'b1;
            r_psync  <= w_boundary;
            r_bcnt   <= w_last ? 8'd0 : r_bcnt + 8'd1;

            if (w_boundary) begin
                r_sel <= w_sel;
                if (w_sel == SEL_PAT) r_pat_due <= 1'b0;
                if (w_sel == SEL_PMT) r_pmt_due <= 1'b0;
            end

            // Clears happen on byte 0 and sets on byte 187, so they never collide;
            // a flag still pending at wrap simply stays set.
            if (w_last) begin
                if (r_sel == SEL_PAT) r_cc_pat <= r_cc_pat + 4'd1;
                if (r_sel == SEL_PMT) r_cc_pmt <= r_cc_pmt + 4'd1;
                if (r_pcnt == PCNT_LAST) begin
                    r_pcnt    <= 16'd0;
                    r_pat_due <= 1'b1;
                    r_pmt_due <= 1'b1;
                end else begin
                    r_pcnt <= r_pcnt + 16'd1;
                end
            end
        end else begin
            r_dvalid <= 1'b0;
            r_psync  <= 1'b0;
        end
    end

    assign bus.DATA_OUT   = r_data;
    assign bus.DVALID_OUT = r_dvalid;
    assign bus.PSYNC_OUT  = r_psync;

endmodule

// File: tb/tb_ts_output_arbiter.sv
module tb_ts_output_arbiter;

    localparam int PERIOD = 8;
    localparam int LEN    = 188;
    localparam int S_PAT  = 0;
    localparam int S_PMT  = 1;
    localparam int S_T2MI = 2;
    localparam int S_NULL = 3;

    logic CLK = 1'b0;
    logic RST;

    ts_output_arbiter_if bus();

    ts_output_arbiter #(.PSI_PERIOD(PERIOD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // ---------------- source models ----------------
    logic [7:0]  pat_pkt [LEN];
    logic [7:0]  pmt_pkt [LEN];
    logic [7:0]  t2mi_mem [4096];
    logic [7:0]  pat_ptr;
    logic [7:0]  pmt_ptr;
    logic [11:0] t_ptr;

    assign bus.PAT_DATA  = pat_pkt[pat_ptr];
    assign bus.PMT_DATA  = pmt_pkt[pmt_ptr];
    assign bus.T2MI_DATA = t2mi_mem[t_ptr];

    // ---------------- packet-level reference model ----------------
    logic [7:0]  m_pkt [LEN];
    int          m_pos;
    bit          m_active;
    int          m_src;
    bit          m_pat_due;
    bit          m_pmt_due;
    int          m_pkts;
    logic [3:0]  m_cc_pat;
    logic [3:0]  m_cc_pmt;
    logic [11:0] m_t_next;

    int total = 0;
    int bad   = 0;
    int ps_cnt, dv_cnt, t2mi_rd_cnt;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Decide and build the whole next packet from the grant rules.
    task automatic m_start(input bit req);
        logic [7:0] hdr;
        if (m_pat_due) begin
            m_src = S_PAT;
            m_pat_due = 1'b0;
            for (int i = 0; i < LEN; i++) m_pkt[i] = pat_pkt[i];
            hdr = pat_pkt[3];
            m_pkt[3] = {hdr[7:4], m_cc_pat};
            m_cc_pat = m_cc_pat + 4'd1;
        end else if (m_pmt_due) begin
            m_src = S_PMT;
            m_pmt_due = 1'b0;
            for (int i = 0; i < LEN; i++) m_pkt[i] = pmt_pkt[i];
            hdr = pmt_pkt[3];
            m_pkt[3] = {hdr[7:4], m_cc_pmt};
            m_cc_pmt = m_cc_pmt + 4'd1;
        end else if (req) begin
            m_src = S_T2MI;
            for (int i = 0; i < LEN; i++) m_pkt[i] = t2mi_mem[m_t_next + 12'(i)];
            m_t_next = m_t_next + 12'(LEN);
        end else begin
            m_src = S_NULL;
            for (int i = 0; i < LEN; i++) m_pkt[i] = 8'hFF;
            m_pkt[0] = 8'h47;
            m_pkt[1] = 8'h1F;
            m_pkt[2] = 8'hFF;
            m_pkt[3] = 8'h10;
        end
        m_pkts++;
        if (m_pkts % PERIOD == 0) begin
            m_pat_due = 1'b1;
            m_pmt_due = 1'b1;
        end
        m_pos = 0;
        m_active = 1'b1;
    endtask

    task automatic m_reset();
        m_active  = 1'b0;
        m_pos     = 0;
        m_src     = S_NULL;
        m_pat_due = 1'b1;
        m_pmt_due = 1'b1;
        m_pkts    = 0;
        m_cc_pat  = 4'd0;
        m_cc_pmt  = 4'd0;
    endtask

    // One clock cycle: drive, check RD strobes, then check registered output.
    task automatic step(input bit ena, input bit req);
        logic rp, rm, rt;
        @(negedge CLK);
        RST = 1'b0;
        bus.OUT_ENA  = ena;
        bus.T2MI_REQ = req;
        #1;
        if (ena && !m_active) m_start(req);
        chk1("pat_rd",  bus.PAT_RD,  ena && m_src == S_PAT);
        chk1("pmt_rd",  bus.PMT_RD,  ena && m_src == S_PMT);
        chk1("t2mi_rd", bus.T2MI_RD, ena && m_src == S_T2MI);
        rp = bus.PAT_RD;
        rm = bus.PMT_RD;
        rt = bus.T2MI_RD;
        @(posedge CLK);
        #1;
        chk1("dvalid", bus.DVALID_OUT, ena);
        if (ena) begin
            chk8("data", bus.DATA_OUT, m_pkt[m_pos]);
            chk1("psync", bus.PSYNC_OUT, m_pos == 0);
            m_pos++;
            if (m_pos == LEN) m_active = 1'b0;
        end else begin
            chk1("psync_idle", bus.PSYNC_OUT, 1'b0);
        end
        if (bus.DVALID_OUT === 1'b1) dv_cnt++;
        if (bus.DVALID_OUT === 1'b1 && bus.PSYNC_OUT === 1'b1) ps_cnt++;
        if (rt === 1'b1) t2mi_rd_cnt++;
        if (rp === 1'b1) pat_ptr = (pat_ptr == 8'(LEN - 1)) ? 8'd0 : pat_ptr + 8'd1;
        if (rm === 1'b1) pmt_ptr = (pmt_ptr == 8'(LEN - 1)) ? 8'd0 : pmt_ptr + 8'd1;
        if (rt === 1'b1) t_ptr = t_ptr + 12'd1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        bus.OUT_ENA  = 1'b1;
        bus.T2MI_REQ = 1'b1;
        #1;
        chk1("rst_pat_rd",  bus.PAT_RD,  1'b0);
        chk1("rst_pmt_rd",  bus.PMT_RD,  1'b0);
        chk1("rst_t2mi_rd", bus.T2MI_RD, 1'b0);
        @(posedge CLK);
        #1;
        chk8("rst_data",   bus.DATA_OUT,   8'h00);
        chk1("rst_dvalid", bus.DVALID_OUT, 1'b0);
        chk1("rst_psync",  bus.PSYNC_OUT,  1'b0);
        m_reset();
        // Sources restart too: PSI generators at byte 0, T2-MI at its next packet.
        pat_ptr = 8'd0;
        pmt_ptr = 8'd0;
        t_ptr   = m_t_next;
    endtask

    initial begin
        int guard;
        bit r_req;
        logic [7:0] b;

        RST = 1'b1;
        bus.OUT_ENA  = 1'b0;
        bus.T2MI_REQ = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            b = 8'($urandom);
            pat_pkt[i] = b;
            b = 8'($urandom);
            pmt_pkt[i] = b;
        end
        pat_pkt[0] = 8'h47; pat_pkt[1] = 8'h40; pat_pkt[2] = 8'h00; pat_pkt[3] = 8'h1A;
        pmt_pkt[0] = 8'h47; pmt_pkt[1] = 8'h41; pmt_pkt[2] = 8'h00; pmt_pkt[3] = 8'h1C;
        for (int i = 0; i < 4096; i++) t2mi_mem[i] = 8'($urandom);
        pat_ptr  = 8'd0;
        pmt_ptr  = 8'd0;
        t_ptr    = 12'd0;
        m_t_next = 12'd0;
        m_reset();
        repeat (2) @(posedge CLK);

        do_reset();

        // PAT, PMT, 6 x T2-MI, then PAT, PMT again
        ps_cnt = 0;
        repeat (10 * LEN) step(1'b1, 1'b1);
        chki("psync_count_cont", ps_cnt, 10);

        // No T2-MI requests: nulls, with PSI still inserted on schedule
        repeat (8 * LEN) step(1'b1, 1'b0);

        // REQ rises at null byte 50, drops at T2-MI byte 10
        t2mi_rd_cnt = 0;
        repeat (50)  step(1'b1, 1'b0);
        repeat (138) step(1'b1, 1'b1);
        repeat (10)  step(1'b1, 1'b1);
        repeat (178) step(1'b1, 1'b0);
        repeat (LEN) step(1'b1, 1'b0);
        chki("t2mi_rd_pulses", t2mi_rd_cnt, LEN);

        // OUT_ENA alternating: 3 packets over 6*188 cycles
        dv_cnt = 0;
        ps_cnt = 0;
        for (int i = 0; i < 6 * LEN; i++) step(i % 2 == 0, 1'b1);
        chki("dvalid_count_alt", dv_cnt, 3 * LEN);
        chki("psync_count_alt", ps_cnt, 3);

        // Long run: enough PSI rounds for the CC counters to wrap
        repeat (120 * LEN) step(1'b1, 1'b1);

        // Random enable and request activity
        r_req = 1'b1;
        repeat (4000) begin
            if ($urandom_range(0, 199) == 0) r_req = !r_req;
            step($urandom_range(0, 3) != 0, r_req);
        end

        // Reach byte 100 of a T2-MI packet, then reset mid-packet
        guard = 0;
        while (!(m_active && m_src == S_T2MI && m_pos == 100) && guard < 3000) begin
            step(1'b1, 1'b1);
            guard++;
        end
        chk1("reach_t2mi_byte100", guard < 3000, 1'b1);
        do_reset();

        // After release: PAT CC 0, PMT CC 0, then T2-MI
        repeat (3 * LEN) step(1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
